dm_arbiter: RTL and testbench

Two-port arbiter that shares the single 128×8 data memory between the SPI slave datapath (port 0) and a local requester such as a debug/host port (port 1). It accepts a request/grant handshake from each requester, drives the memory's address, write-enable and write-data lines for exactly one cycle per access, and returns registered read data with a valid pulse. It sits between the requesters and the data memory; the memory itself is unchanged.

---
 rtl/dm_arb_pkg.sv | 16 +
 rtl/dm_arbiter_if.sv | 31 +++
 rtl/dm_arb_pick.sv | 43 ++++
 rtl/dm_arbiter.sv | 90 +++++++++
 tb/tb_dm_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: shared types and constants for the data-memory arbiter.
package dm_arb_pkg;

   localparam int unsigned ADDR_W = 7;
   localparam int unsigned DATA_W = 8;

   localparam logic PORT_SPI = 1'b0;
   localparam logic PORT_LCL = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } arb_state_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: requester handshake plus data-memory bus of the arbiter.
// master = requesters/memory side, slave = arbiter side.
interface dm_arbiter_if #(
   parameter int unsigned ADDR_W = dm_arb_pkg::ADDR_W,
   parameter int unsigned DATA_W = dm_arb_pkg::DATA_W
);
   logic [1:0]        req;
   logic [1:0]        we;
   logic [1:0]        lock;
   logic [ADDR_W-1:0] addr0;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] wdata0;
   logic [DATA_W-1:0] wdata1;
   logic [1:0]        gnt;
   logic [1:0]        rvalid;
   logic [DATA_W-1:0] rdata;
   logic [ADDR_W-1:0] dm_addr;
   logic              dm_we;
   logic [DATA_W-1:0] dm_din;
   logic [DATA_W-1:0] dm_dout;

   modport master (
      output req, we, lock, addr0, addr1, wdata0, wdata1, dm_dout,
      input  gnt, rvalid, rdata, dm_addr, dm_we, dm_din
   );

   modport slave (
      input  req, we, lock, addr0, addr1, wdata0, wdata1, dm_dout,
      output gnt, rvalid, rdata, dm_addr, dm_we, dm_din
   );
endinterface

// File: rtl/dm_arb_pick.sv
// dm_arb_pick: combinational winner selection for the data-memory arbiter.
// Build option: DM_ARB_ROUND_ROBIN_EN -> contention goes to the port that
// was not served last; undefined -> port 0 always wins contention.
module dm_arb_pick
   import dm_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic [1:0] lock,
   input  logic       owner,
   input  logic       last,
   input  arb_state_t state,
   output logic       valid,
   output logic       winner
);

`ifndef DM_ARB_ROUND_ROBIN_EN
   logic unused_last;
   assign unused_last = last;
`endif

   // Lock continuation first, then a lone requester, then contention policy
   always_comb begin
      valid  = 1'b0;
      winner = PORT_SPI;
      if (state != ACCESS && req != 2'b00) begin
         valid = 1'b1;
         if (state == RESP && lock[owner] && req[owner]) begin
            winner = owner;
         end else if (req == 2'b01) begin
            winner = PORT_SPI;
         end else if (req == 2'b10) begin
            winner = PORT_LCL;
         end else begin
`ifdef DM_ARB_ROUND_ROBIN_EN
            winner = ~last;
`else
            winner = PORT_SPI;
`endif
         end
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data memory between the SPI datapath (port 0) and
// a local requester (port 1). One access = ACCESS cycle (gnt) + RESP cycle
// (rvalid); arbitration happens at the edges leaving IDLE and RESP.
// Build option: DM_ARB_ROUND_ROBIN_EN (contention policy, see dm_arb_pick).
module dm_arbiter #(
   parameter int unsigned ADDR_W = dm_arb_pkg::ADDR_W,
   parameter int unsigned DATA_W = dm_arb_pkg::DATA_W
) (
   input logic         clk,
   input logic         reset,
   dm_arbiter_if.slave bus
);
   import dm_arb_pkg::*;

   arb_state_t        state;
   arb_state_t        state_nxt;
   logic              owner;
   logic              last;
   logic              pick_valid;
   logic              pick_winner;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   dm_arb_pick u_pick (
      .req    (bus.req),
      .lock   (bus.lock),
      .owner  (owner),
      .last   (last),
      .state  (state),
      .valid  (pick_valid),
      .winner (pick_winner)
   );

   // Next state, per-port strobes and winner request-field mux
   always_comb begin
      state_nxt  = state;
      bus.gnt    = '0;
      bus.rvalid = '0;
      win_we     = bus.we[pick_winner];
      win_addr   = pick_winner ? bus.addr1  : bus.addr0;
      win_wdata  = pick_winner ? bus.wdata1 : bus.wdata0;
      unique case (state)
         IDLE:    state_nxt = pick_valid ? ACCESS : IDLE;
         ACCESS: begin
            bus.gnt[owner] = 1'b1;
            state_nxt      = RESP;
         end
         RESP: begin
            bus.rvalid[owner] = 1'b1;
            state_nxt         = pick_valid ? ACCESS : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, owner and last-served registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         owner <= PORT_SPI;
         last  <= PORT_LCL;
      end else begin
         state <= state_nxt;
         if (state == ACCESS) last  <= owner;
         if (pick_valid)      owner <= pick_winner;
      end
   end

   // Registered memory bus and read-data capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.dm_addr <= '0;
         bus.dm_we   <= 1'b0;
         bus.dm_din  <= '0;
         bus.rdata   <= '0;
      end else begin
         if (state == ACCESS) begin
            bus.rdata <= bus.dm_dout;
            bus.dm_we <= 1'b0;
         end
         if (pick_valid) begin
            bus.dm_we   <= win_we;
            bus.dm_addr <= win_addr;
            bus.dm_din  <= win_wdata;
         end
      end
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: scoreboard bench for dm_arbiter with a memory model,
// a queue-driven requester per port and a transaction-level reference.
// Build option mirrored: DM_ARB_ROUND_ROBIN_EN.
`timescale 1ns/1ps
module tb_dm_arbiter;

   typedef struct packed {
      logic       we;
      logic [6:0] addr;
      logic [7:0] wdata;
      logic       lock;
      logic [3:0] gap;
   } item_t;

   typedef struct packed {
      logic       port;
      logic       we;
      logic [6:0] addr;
      logic [7:0] wdata;
   } acc_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic load_mem = 1'b1;
   always #5 clk = ~clk;

   dm_arbiter_if #(.ADDR_W(7), .DATA_W(8)) bus ();

   dm_arbiter #(.ADDR_W(7), .DATA_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int unsigned errors = 0;
   int unsigned checks = 0;

   item_t q0[$];
   item_t q1[$];
   acc_t  sb[$];
   int    glog[$];
   logic  act [2];

   logic [7:0] mem     [128];
   logic [7:0] ref_mem [128];

   function automatic logic [7:0] seed(input int i);
      return 8'((i * 29) ^ 90);
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Data memory model: combinational read, write at the clock edge
   assign bus.dm_dout = mem[bus.dm_addr];
   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 128; i++) mem[i] <= seed(i);
      end else if (bus.dm_we) begin
         mem[bus.dm_addr] <= bus.dm_din;
      end
   end

   // Inputs as sampled by the DUT at each rising edge
   logic [1:0] s_req, s_we, s_lock;
   logic [6:0] s_addr  [2];
   logic [7:0] s_wdata [2];
   always @(posedge clk) begin
      s_req      = bus.req;
      s_we       = bus.we;
      s_lock     = bus.lock;
      s_addr[0]  = bus.addr0;
      s_addr[1]  = bus.addr1;
      s_wdata[0] = bus.wdata0;
      s_wdata[1] = bus.wdata1;
   end

   function automatic int qsize(input int p);
      return (p == 0) ? q0.size() : q1.size();
   endfunction

   function automatic item_t qfront(input int p);
      return (p == 0) ? q0[0] : q1[0];
   endfunction

   // Requesters: hold a request until gnt, optionally re-request in the gnt cycle
   initial begin
      int unsigned wait_cnt [2];
      int unsigned gap_cnt  [2];
      item_t it;
      bus.req = '0; bus.we = '0; bus.lock = '0;
      bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
      for (int p = 0; p < 2; p++) begin
         act[p] = 1'b0; wait_cnt[p] = 0; gap_cnt[p] = 0;
      end
      forever begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (act[p]) begin
               if (bus.gnt[p]) begin
                  act[p] = 1'b0;
               end else if (wait_cnt[p] >= 200) begin
                  checks++; errors++;
                  $display("FAIL grant_timeout: port %0d got no gnt within 200 cycles", p);
                  act[p] = 1'b0;
               end else begin
                  wait_cnt[p]++;
               end
            end
            if (!act[p]) begin
               if (qsize(p) != 0 && gap_cnt[p] >= int'(qfront(p).gap)) begin
                  if (p == 0) begin
                     it = q0.pop_front();
                     bus.addr0 = it.addr; bus.wdata0 = it.wdata;
                  end else begin
                     it = q1.pop_front();
                     bus.addr1 = it.addr; bus.wdata1 = it.wdata;
                  end
                  bus.req[p] = 1'b1; bus.we[p] = it.we; bus.lock[p] = it.lock;
                  act[p] = 1'b1; wait_cnt[p] = 0; gap_cnt[p] = 0;
               end else begin
                  bus.req[p] = 1'b0; bus.lock[p] = 1'b0;
                  if (qsize(p) != 0) gap_cnt[p]++;
               end
            end
         end
      end
   end

   // Reference model + scoreboard monitor: grants from the arbitration rules,
   // responses from a transaction-level memory image
   initial begin
      logic       g_prev, rv_prev, m_last, w, g_now, rv_now;
      logic [1:0] exp_gnt, exp_rv;
      logic [7:0] hold, exp_rd;
      acc_t       a;
      for (int i = 0; i < 128; i++) ref_mem[i] = seed(i);
      g_prev = 1'b0; rv_prev = 1'b0; m_last = 1'b1; hold = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            sb.delete();
            g_prev = 1'b0; rv_prev = 1'b0; m_last = 1'b1; hold = '0;
            continue;
         end
         rv_now = g_prev;
         exp_rv = rv_now ? (2'b01 << m_last) : 2'b00;
         check("rvalid", 32'(bus.rvalid), 32'(exp_rv));
         if (bus.rvalid != 2'b00) begin
            if (sb.size() == 0) begin
               check("rvalid_unexpected", 32'(bus.rvalid), 32'd0);
            end else begin
               a = sb.pop_front();
               exp_rd = ref_mem[a.addr];
               check("rvalid_port", 32'(bus.rvalid), 32'(2'b01 << a.port));
               check("rdata", 32'(bus.rdata), 32'(exp_rd));
               if (a.we) ref_mem[a.addr] = a.wdata;
               hold = exp_rd;
            end
         end else begin
            check("rdata_hold", 32'(bus.rdata), 32'(hold));
         end

         g_now = !g_prev && (s_req != 2'b00);
         w = 1'b0;
         if (g_now) begin
            if (rv_prev && s_lock[m_last] && s_req[m_last]) w = m_last;
            else if (s_req == 2'b10) w = 1'b1;
            else if (s_req == 2'b01) w = 1'b0;
`ifdef DM_ARB_ROUND_ROBIN_EN
            else w = !m_last;
`else
            else w = 1'b0;
`endif
         end
         exp_gnt = g_now ? (2'b01 << w) : 2'b00;
         check("gnt", 32'(bus.gnt), 32'(exp_gnt));
         if (g_now) begin
            check("dm_addr", 32'(bus.dm_addr), 32'(s_addr[w]));
            check("dm_we", 32'(bus.dm_we), 32'(s_we[w]));
            check("dm_din", 32'(bus.dm_din), 32'(s_wdata[w]));
            a.port = w; a.we = s_we[w]; a.addr = s_addr[w]; a.wdata = s_wdata[w];
            sb.push_back(a);
            glog.push_back(int'(w));
            m_last = w;
         end else begin
            check("dm_we_idle", 32'(bus.dm_we), 32'd0);
         end
         rv_prev = rv_now;
         g_prev  = g_now;
      end
   end

   task automatic push(input int p, input logic we, input logic [6:0] addr,
                       input logic [7:0] wdata, input logic lock, input int gap);
      item_t it;
      it.we = we; it.addr = addr; it.wdata = wdata; it.lock = lock; it.gap = 4'(gap);
      if (p == 0) q0.push_back(it); else q1.push_back(it);
   endtask

   task automatic drain();
      int unsigned n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || act[0] || act[1] || sb.size() != 0)
             && n < 3000) begin
         @(negedge clk); #1;
         n++;
      end
      check("drain_timeout", 32'(n >= 3000), 32'd0);
      repeat (3) @(negedge clk);
      #2;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
      check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd0);
      check({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
      check({tag, "_dm_addr"}, 32'(bus.dm_addr), 32'd0);
      check({tag, "_dm_we"}, 32'(bus.dm_we), 32'd0);
      check({tag, "_dm_din"}, 32'(bus.dm_din), 32'd0);
   endtask

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Directed scenarios followed by random traffic
   initial begin
      int exp_seq[$];
      int unsigned n;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      #2 reset = 1'b0; load_mem = 1'b0;

      // Continuous dual reads of 0x01 / 0x02
      glog.delete();
      for (int i = 0; i < 6; i++) begin
         push(0, 1'b0, 7'h01, 8'h00, 1'b0, 0);
         push(1, 1'b0, 7'h02, 8'h00, 1'b0, 0);
      end
      drain();
      exp_seq.delete();
`ifdef DM_ARB_ROUND_ROBIN_EN
      for (int i = 0; i < 12; i++) exp_seq.push_back(i % 2);
`else
      for (int i = 0; i < 12; i++) exp_seq.push_back(i < 6 ? 0 : 1);
`endif
      check("alt_count", 32'(glog.size()), 32'd12);
      for (int i = 0; i < 12 && i < glog.size(); i++)
         check("alt_order", 32'(glog[i]), 32'(exp_seq[i]));

      // Port 1 write 0xA5 to 0x12 then read it back
      push(1, 1'b1, 7'h12, 8'hA5, 1'b0, 0);
      push(1, 1'b0, 7'h12, 8'h00, 1'b0, 2);
      drain();

      // Port 1 locked burst of three reads against a waiting port 0
      glog.delete();
      push(1, 1'b0, 7'h20, 8'h00, 1'b1, 0);
      push(1, 1'b0, 7'h21, 8'h00, 1'b1, 0);
      push(1, 1'b0, 7'h22, 8'h00, 1'b1, 0);
      push(0, 1'b0, 7'h30, 8'h00, 1'b0, 2);
      drain();
      check("lock_count", 32'(glog.size()), 32'd4);
      exp_seq = '{1, 1, 1, 0};
      for (int i = 0; i < 4 && i < glog.size(); i++)
         check("lock_order", 32'(glog[i]), 32'(exp_seq[i]));

      // Single write after an idle gap
      repeat (5) @(negedge clk);
      push(0, 1'b1, 7'h33, 8'h5E, 1'b0, 0);
      drain();

      // Reset in the ACCESS cycle of a write: the write must be dropped
      push(0, 1'b1, 7'h40, 8'h3C, 1'b0, 0);
      n = 0;
      do begin
         @(negedge clk); #1;
         n++;
      end while (!bus.gnt[0] && n < 50);
      check("rst_wait_gnt", 32'(bus.gnt[0]), 32'd1);
      check("rst_pre_dm_we", 32'(bus.dm_we), 32'd1);
      #1 reset = 1'b1;
      #1 check_reset_outputs("midreset");
      @(negedge clk); #1;
      check("midreset_mem", 32'(mem[7'h40]), 32'(seed(8'h40)));
      #1 reset = 1'b0;
      push(0, 1'b0, 7'h40, 8'h00, 1'b0, 0);
      drain();

      // Port 0 re-requests in its gnt cycle with a new address
      push(0, 1'b0, 7'h05, 8'h00, 1'b0, 0);
      push(0, 1'b0, 7'h06, 8'h00, 1'b0, 0);
      drain();

      // Random traffic on both ports
      for (int i = 0; i < 40; i++) begin
         for (int p = 0; p < 2; p++)
            push(p, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 15)),
                 8'($urandom), 1'($urandom_range(0, 3) == 0), $urandom_range(0, 3));
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
